// File: rtl/spectrum_frame_engine.sv
// Spectrum capture engine: collects a sample frame, streams it to an external FFT and
// stores a scaled |X|^2 per bin in a ping-pong display RAM. Optional macro: PEAK_HOLD_EN.
module spectrum_frame_engine #(
  parameter int SAMPLE_W  = 8,
  parameter int LOG2N     = 9,
  parameter int DISP_W    = 9,
  parameter int MAG_SHIFT = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [SAMPLE_W-1:0] fft_xn_re,
  output logic                fft_xn_valid,
  output logic                fft_start,
  input  logic [SAMPLE_W-1:0] fft_xk_re,
  input  logic [SAMPLE_W-1:0] fft_xk_im,
  input  logic [LOG2N-1:0]    fft_xk_index,
  input  logic                fft_dv,
  input  logic [LOG2N-1:0]    rd_addr,
  output logic [DISP_W-1:0]   rd_data,
  output logic [15:0]         frame_count,
  output logic                overflow
);

  localparam int N  = 1 << LOG2N;
  localparam int PW = 2 * SAMPLE_W;
  localparam int SW = PW + 1;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [SW-1:0]    SAT_LIM  = SW'((1 << DISP_W) - 1);

  typedef enum logic [1:0] {COLLECT, LOAD, UNLOAD, SWAP} state_e;

  state_e            state_q, state_d;
  logic [LOG2N-1:0]  wptr_q, wptr_d;
  logic [LOG2N-1:0]  rptr_q, rptr_d;
  logic              frontSel_q, frontSel_d;
  logic [15:0]       frameCount_q, frameCount_d;
  logic              overflow_q;
  logic              inWrEn;
  logic              loadRd;

  logic [SAMPLE_W-1:0] inBuf [N];
  logic [SAMPLE_W-1:0] xnData_q;
  logic                xnValid_q;
  logic                xnStart_q;

  logic                       s1Valid_q;
  logic [PW-1:0]              reSq_q, imSq_q;
  logic [LOG2N-1:0]           s1Index_q;
  logic signed [SAMPLE_W-1:0] xkRe, xkIm;
  logic [SW-1:0]              magSum, magShift;
  logic [DISP_W-1:0]          magSat, wrVal;
  logic                       dispWrEn;

  logic [DISP_W-1:0] dispBuf0 [N];
  logic [DISP_W-1:0] dispBuf1 [N];
  logic [DISP_W-1:0] rdData_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      wptr_q       <= '0;
      rptr_q       <= '0;
      frontSel_q   <= 1'b0;
      frameCount_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      frontSel_q   <= frontSel_d;
      frameCount_q <= frameCount_d;
      overflow_q   <= overflow_q | (s_valid & ~s_ready);
    end
  end

  // SWAP waits for the bin N-1 write, which happens on the same edge as the transition.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    frontSel_d   = frontSel_q;
    frameCount_d = frameCount_q;
    inWrEn       = 1'b0;
    loadRd       = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_valid) begin
          inWrEn = 1'b1;
          wptr_d = wptr_q + LOG2N'(1);
          if (wptr_q == LAST_IDX) state_d = LOAD;
        end
      end
      LOAD: begin
        loadRd = 1'b1;
        rptr_d = rptr_q + LOG2N'(1);
        if (rptr_q == LAST_IDX) state_d = UNLOAD;
      end
      UNLOAD: begin
        if (s1Valid_q && (s1Index_q == LAST_IDX)) state_d = SWAP;
      end
      SWAP: begin
        frontSel_d   = ~frontSel_q;
        frameCount_d = frameCount_q + 16'd1;
        state_d      = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (inWrEn && !rst) inBuf[wptr_q] <= s_data;
    xnData_q <= inBuf[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xnValid_q <= 1'b0;
      xnStart_q <= 1'b0;
    end else begin
      xnValid_q <= loadRd;
      xnStart_q <= loadRd && (rptr_q == '0);
    end
  end

  assign xkRe = fft_xk_re;
  assign xkIm = fft_xk_im;

  always_ff @(posedge clk) begin
    if (rst) s1Valid_q <= 1'b0;
    else     s1Valid_q <= fft_dv && (state_q == UNLOAD);
    reSq_q    <= PW'(xkRe) * PW'(xkRe);
    imSq_q    <= PW'(xkIm) * PW'(xkIm);
    s1Index_q <= fft_xk_index;
  end

  // Squares are never negative, so the sum is treated as unsigned.
  assign magSum   = SW'(reSq_q) + SW'(imSq_q);
  assign magShift = magSum >> MAG_SHIFT;
  assign magSat   = (magShift > SAT_LIM) ? DISP_W'(SAT_LIM) : magShift[DISP_W-1:0];

`ifdef PEAK_HOLD_EN
  logic [DISP_W-1:0] oldFront_q;
  logic [DISP_W-1:0] decayed;

  always_ff @(posedge clk) begin
    oldFront_q <= frontSel_q ? dispBuf1[fft_xk_index] : dispBuf0[fft_xk_index];
  end

  always_comb begin
    decayed = (oldFront_q == '0) ? '0 : oldFront_q - DISP_W'(1);
    wrVal   = (magSat > decayed) ? magSat : decayed;
  end
`else
  assign wrVal = magSat;
`endif

  assign dispWrEn = s1Valid_q && !rst;

  always_ff @(posedge clk) begin
    if (dispWrEn) begin
      if (frontSel_q) dispBuf0[s1Index_q] <= wrVal;
      else            dispBuf1[s1Index_q] <= wrVal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdData_q <= '0;
    else     rdData_q <= frontSel_q ? dispBuf1[rd_addr] : dispBuf0[rd_addr];
  end

  assign s_ready      = (state_q == COLLECT);
  assign fft_xn_re    = xnData_q;
  assign fft_xn_valid = xnValid_q;
  assign fft_start    = xnStart_q;
  assign rd_data      = rdData_q;
  assign frame_count  = frameCount_q;
  assign overflow     = overflow_q;

endmodule
